// File: rtl/fpadd_lane_packer.sv
// fpadd_lane_packer: issue stage in front of the dual-lane FP adder.
// FP32 ops pass straight through. Two consecutive FP16-lane ops share one
// issue word (older op in the hi lane). A lone FP16 op is sent with an
// all-zero lo lane on timeout, on flush, or ahead of an FP32 op.

package fpadd_lane_packer_pkg;
  typedef enum logic {
    FP32 = 1'b0,
    FP16 = 1'b1
  } fp_fmt_e;
endpackage

module fpadd_lane_packer
  import fpadd_lane_packer_pkg::*;
#(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  fp_fmt_e          in_fmt,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output fp_fmt_e          out_fmt,
  output logic [31:0]      out_x,
  output logic [31:0]      out_y,
  output logic             out_lo_valid,
  output logic [TAG_W-1:0] out_tag_hi,
  output logic [TAG_W-1:0] out_tag_lo
);

  // Timer needs at least one bit even when TIMEOUT is 1.
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e             state_r;
  logic [TMR_W-1:0]   timer_r;
  logic [15:0]        pend_x_r;
  logic [15:0]        pend_y_r;
  logic [TAG_W-1:0]   pend_tag_r;

  logic               out_valid_r;
  fp_fmt_e            out_fmt_r;
  logic [31:0]        out_x_r;
  logic [31:0]        out_y_r;
  logic               out_lo_valid_r;
  logic [TAG_W-1:0]   out_tag_hi_r;
  logic [TAG_W-1:0]   out_tag_lo_r;

  logic               can_load_s;
  logic               fp16_in_s;
  logic               timeout_s;
  logic               in_ready_s;
  logic               load_fp32_s;
  logic               store_s;
  logic               pair_s;
  logic               lone_s;

  // Decide this cycle's action: FP32 pass-through, park an FP16 op, pair, or lone flush.
  always_comb begin
    can_load_s  = !out_valid_r || out_ready;
    fp16_in_s   = (in_fmt == FP16);
    timeout_s   = (timer_r == TMR_MAX);
    in_ready_s  = 1'b0;
    load_fp32_s = 1'b0;
    store_s     = 1'b0;
    pair_s      = 1'b0;
    lone_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        in_ready_s = can_load_s;
        if (in_valid && can_load_s) begin
          if (fp16_in_s) begin
            store_s = 1'b1;
          end else begin
            load_fp32_s = 1'b1;
          end
        end else begin
          store_s     = 1'b0;
          load_fp32_s = 1'b0;
        end
      end
      ST_HOLD: begin
        // An FP32 op must wait until the lone hi-lane op has left.
        if (fp16_in_s) begin
          in_ready_s = can_load_s;
        end else begin
          in_ready_s = 1'b0;
        end
        // Pairing takes priority over timeout and flush in the same cycle.
        if (in_valid && fp16_in_s && can_load_s) begin
          pair_s = 1'b1;
        end else if (can_load_s && ((in_valid && !fp16_in_s) || flush || timeout_s)) begin
          lone_s = 1'b1;
        end else begin
          pair_s = 1'b0;
          lone_s = 1'b0;
        end
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // State, pending hi-lane op, wait timer and the single output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      timer_r        <= '0;
      pend_x_r       <= 16'h0000;
      pend_y_r       <= 16'h0000;
      pend_tag_r     <= '0;
      out_valid_r    <= 1'b0;
      out_fmt_r      <= FP32;
      out_x_r        <= 32'h0000_0000;
      out_y_r        <= 32'h0000_0000;
      out_lo_valid_r <= 1'b0;
      out_tag_hi_r   <= '0;
      out_tag_lo_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (store_s) begin
            pend_x_r   <= in_x[15:0];
            pend_y_r   <= in_y[15:0];
            pend_tag_r <= in_tag;
            timer_r    <= '0;
            state_r    <= ST_HOLD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (pair_s || lone_s) begin
            timer_r <= '0;
            state_r <= ST_IDLE;
          end else if (!timeout_s) begin
            timer_r <= timer_r + TMR_W'(1);
          end else begin
            timer_r <= timer_r;
          end
        end
        default: begin
          timer_r <= '0;
          state_r <= ST_IDLE;
        end
      endcase

      if (load_fp32_s) begin
        out_valid_r    <= 1'b1;
        out_fmt_r      <= FP32;
        out_x_r        <= in_x;
        out_y_r        <= in_y;
        out_lo_valid_r <= 1'b0;
        out_tag_hi_r   <= in_tag;
        out_tag_lo_r   <= '0;
      end else if (pair_s) begin
        out_valid_r    <= 1'b1;
        out_fmt_r      <= FP16;
        out_x_r        <= {pend_x_r, in_x[15:0]};
        out_y_r        <= {pend_y_r, in_y[15:0]};
        out_lo_valid_r <= 1'b1;
        out_tag_hi_r   <= pend_tag_r;
        out_tag_lo_r   <= in_tag;
      end else if (lone_s) begin
        out_valid_r    <= 1'b1;
        out_fmt_r      <= FP16;
        out_x_r        <= {pend_x_r, 16'h0000};
        out_y_r        <= {pend_y_r, 16'h0000};
        out_lo_valid_r <= 1'b0;
        out_tag_hi_r   <= pend_tag_r;
        out_tag_lo_r   <= '0;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_r;
  assign out_fmt      = out_fmt_r;
  assign out_x        = out_x_r;
  assign out_y        = out_y_r;
  assign out_lo_valid = out_lo_valid_r;
  assign out_tag_hi   = out_tag_hi_r;
  assign out_tag_lo   = out_tag_lo_r;

endmodule

// File: tb/tb_fpadd_lane_packer.sv
// Directed bench for fpadd_lane_packer with hand-computed expectations.

module tb_fpadd_lane_packer;
  import fpadd_lane_packer_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  fp_fmt_e     in_fmt;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [3:0]  in_tag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  fp_fmt_e     out_fmt;
  logic [31:0] out_x;
  logic [31:0] out_y;
  logic        out_lo_valid;
  logic [3:0]  out_tag_hi;
  logic [3:0]  out_tag_lo;

  int checks_cnt;
  int errors_cnt;

  fpadd_lane_packer #(.TAG_W(4), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_fmt       (in_fmt),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_tag       (in_tag),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_fmt      (out_fmt),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_lo_valid (out_lo_valid),
    .out_tag_hi   (out_tag_hi),
    .out_tag_lo   (out_tag_lo)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt = checks_cnt + 1;
    if (got !== exp) begin
      errors_cnt = errors_cnt + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input fp_fmt_e f, input logic [31:0] x,
                       input logic [31:0] y, input logic [3:0] t);
    in_valid = v;
    in_fmt   = f;
    in_x     = x;
    in_y     = y;
    in_tag   = t;
    #1;
  endtask

  task automatic check_word(input string tag, input fp_fmt_e f, input logic [31:0] x,
                            input logic [31:0] y, input logic lo, input logic [3:0] th,
                            input logic [3:0] tl);
    check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
    check_val({tag, "_fmt"}, 64'(out_fmt), 64'(f));
    check_val({tag, "_x"}, 64'(out_x), 64'(x));
    check_val({tag, "_y"}, 64'(out_y), 64'(y));
    check_val({tag, "_lo_valid"}, 64'(out_lo_valid), 64'(lo));
    check_val({tag, "_tag_hi"}, 64'(out_tag_hi), 64'(th));
    check_val({tag, "_tag_lo"}, 64'(out_tag_lo), 64'(tl));
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_fmt    = FP32;
    in_x      = 32'h0;
    in_y      = 32'h0;
    in_tag    = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_lo_valid", 64'(out_lo_valid), 64'd0);
    check_val("rst_x", 64'(out_x), 64'd0);
    check_val("rst_y", 64'(out_y), 64'd0);
    check_val("rst_tags", 64'({out_tag_hi, out_tag_lo}), 64'd0);
    check_val("rst_fmt", 64'(out_fmt), 64'(FP32));
    check_val("rst_in_ready", 64'(in_ready), 64'd1);

    // FP32 pass-through
    drive(1'b1, FP32, 32'h3F80_0000, 32'h4000_0000, 4'd1);
    check_val("fp32_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, FP32, 32'h0, 32'h0, 4'd0);
    check_word("fp32", FP32, 32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd1, 4'd0);
    tick();
    check_val("fp32_drain", 64'(out_valid), 64'd0);

    // FP16 pair; upper operand bits of the partner must be ignored
    drive(1'b1, FP16, 32'h0000_3F80, 32'h0000_4000, 4'd2);
    tick();
    check_val("pair_a_no_out", 64'(out_valid), 64'd0);
    drive(1'b1, FP16, 32'hDEAD_4040, 32'hBEEF_3F80, 4'd3);
    check_val("pair_b_in_ready", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, FP32, 32'h0, 32'h0, 4'd0);
    check_word("pair", FP16, 32'h3F80_4040, 32'h4000_3F80, 1'b1, 4'd2, 4'd3);
    tick();

    // Lone FP16 times out exactly 8 cycles after acceptance
    drive(1'b1, FP16, 32'h0000_3F80, 32'h0000_3F80, 4'd5);
    tick();
    drive(1'b0, FP32, 32'h0, 32'h0, 4'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      check_val($sformatf("lone_wait%0d", k), 64'(out_valid), 64'd0);
    end
    tick();
    check_word("lone", FP16, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 4'd5, 4'd0);
    tick();

    // FP16 followed by FP32: lone flush first, FP32 next cycle
    drive(1'b1, FP16, 32'h0000_1111, 32'h0000_2222, 4'd6);
    tick();
    drive(1'b1, FP32, 32'hAAAA_5555, 32'h5555_AAAA, 4'd7);
    check_val("f32after_in_ready0", 64'(in_ready), 64'd0);
    tick();
    check_word("f32after_lone", FP16, 32'h1111_0000, 32'h2222_0000, 1'b0, 4'd6, 4'd0);
    check_val("f32after_in_ready1", 64'(in_ready), 64'd1);
    tick();
    drive(1'b0, FP32, 32'h0, 32'h0, 4'd0);
    check_word("f32after_fp32", FP32, 32'hAAAA_5555, 32'h5555_AAAA, 1'b0, 4'd7, 4'd0);
    tick();

    // Backpressure: paired word held 20 cycles, next FP16 refused
    out_ready = 1'b0;
    drive(1'b1, FP16, 32'h0000_0A0A, 32'h0000_0B0B, 4'd9);
    tick();
    drive(1'b1, FP16, 32'h0000_0C0C, 32'h0000_0D0D, 4'd10);
    tick();
    drive(1'b1, FP16, 32'h0000_0E0E, 32'h0000_0F0F, 4'd11);
    for (int k = 0; k < 20; k++) begin
      check_val($sformatf("bp_in_ready%0d", k), 64'(in_ready), 64'd0);
      check_val($sformatf("bp_stable%0d", k),
                64'({out_valid, out_lo_valid, out_x}), 64'({1'b1, 1'b1, 32'h0A0A_0C0C}));
      tick();
    end
    check_word("bp_word", FP16, 32'h0A0A_0C0C, 32'h0B0B_0D0D, 1'b1, 4'd9, 4'd10);
    out_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    check_val("bp_drained", 64'(out_valid), 64'd0);
    drive(1'b1, FP16, 32'h0000_1010, 32'h0000_2020, 4'd12);
    tick();
    drive(1'b0, FP32, 32'h0, 32'h0, 4'd0);
    check_word("bp_next", FP16, 32'h0E0E_1010, 32'h0F0F_2020, 1'b1, 4'd11, 4'd12);
    tick();

    // Reset while holding a lone op: it must never issue
    drive(1'b1, FP16, 32'h0000_7777, 32'h0000_7777, 4'd4);
    tick();
    drive(1'b0, FP32, 32'h0, 32'h0, 4'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_val("rsthold_out_valid", 64'(out_valid), 64'd0);
    check_val("rsthold_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val($sformatf("rsthold_quiet%0d", k), 64'(out_valid), 64'd0);
    end
    drive(1'b1, FP16, 32'h0000_1234, 32'h0000_5678, 4'd1);
    tick();
    drive(1'b1, FP16, 32'h0000_9ABC, 32'h0000_DEF0, 4'd2);
    tick();
    drive(1'b0, FP32, 32'h0, 32'h0, 4'd0);
    check_word("rsthold_fresh", FP16, 32'h1234_9ABC, 32'h5678_DEF0, 1'b1, 4'd1, 4'd2);
    tick();

    // Flush in HOLD sends a lone word
    drive(1'b1, FP16, 32'h0000_0101, 32'h0000_0202, 4'd3);
    tick();
    drive(1'b0, FP32, 32'h0, 32'h0, 4'd0);
    flush = 1'b1;
    tick();
    check_word("flush_lone", FP16, 32'h0101_0000, 32'h0202_0000, 1'b0, 4'd3, 4'd0);
    // Flush in IDLE does nothing
    tick();
    check_val("flush_idle", 64'(out_valid), 64'd0);

    // Pairing beats flush in the same cycle
    flush = 1'b0;
    drive(1'b1, FP16, 32'h0000_AAAA, 32'h0000_BBBB, 4'd13);
    tick();
    flush = 1'b1;
    drive(1'b1, FP16, 32'h0000_CCCC, 32'h0000_DDDD, 4'd14);
    tick();
    flush = 1'b0;
    drive(1'b0, FP32, 32'h0, 32'h0, 4'd0);
    check_word("pair_vs_flush", FP16, 32'hAAAA_CCCC, 32'hBBBB_DDDD, 1'b1, 4'd13, 4'd14);
    tick();
    check_val("final_drain", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
